vp_cart_loader: RTL and testbench



---
 rtl/vp_cart_pkg.sv | 32 +++
 rtl/vp_cyc_timer.sv | 28 ++
 rtl/vp_cart_loader.sv | 255 +++++++++++++++++++++++++
 tb/tb_vp_cart_loader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_cart_pkg.sv
// Shared definitions for the cartridge SRAM loader: PAGEMODE codes, image size
// limit, loader state encoding and the checksum helper.
package vp_cart_pkg;

    localparam logic [2:0] PM_P10P11 = 3'b000;
    localparam logic [2:0] PM_VPPLUS = 3'b001;
    localparam logic [2:0] PM_SOREN  = 3'b010;
    localparam logic [2:0] PM_SELECT = 3'b011;
    localparam logic [2:0] PM_SEND   = 3'b100;
    localparam logic [2:0] PM_XROM   = 3'b101;
    localparam logic [2:0] PM_TEST   = 3'b110;

    localparam logic [15:0] MAX_GAME_LEN = 16'd32768;
    localparam int unsigned TMR_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_W_SETUP = 3'd2,
        ST_W_PULSE = 3'd3,
        ST_W_HOLD  = 3'd4,
        ST_R_SETUP = 3'd5,
        ST_R_WAIT  = 3'd6,
        ST_FINISH  = 3'd7
    } ld_state_e;

    // Additive image checksum, wraps modulo 2^16.
    function automatic logic [15:0] csum_add(input logic [15:0] sum, input logic [7:0] data);
        return sum + {8'h00, data};
    endfunction

endpackage

// File: rtl/vp_cyc_timer.sv
// Loadable down-counter used to time the write/read bus phases; o_done is high
// while the count sits at zero, so loading N-1 yields an N-cycle phase.
module vp_cyc_timer
    import vp_cart_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    output logic             o_done
);

    logic [TMR_W-1:0] r_cnt;

    // Phase counter: load on phase entry, then count down to zero and park.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {TMR_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != {TMR_W{1'b0}}) begin
            r_cnt <= r_cnt - {{(TMR_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_done = (r_cnt == {TMR_W{1'b0}});

endmodule

// File: rtl/vp_cart_loader.sv
// Streams a game image into cartridge SRAM over the ARDA/ARDD port, optionally
// verifies it by readback checksum, then hands the RAM over via PAGEMODE.
module vp_cart_loader
    import vp_cart_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned READ_CYC  = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_game_len,
    input  logic        i_verify,
    input  logic [2:0]  i_mode_in,
    input  logic [7:0]  i_s_data,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    output logic [14:0] o_arda,
    output logic [7:0]  o_ardd_o,
    output logic        o_ardd_oe,
    input  logic [7:0]  i_ardd_i,
    output logic        o_ardwe,
    output logic        o_ardoe,
    output logic [2:0]  o_pagemode,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_checksum
);

    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] READ_LD  = TMR_W'(READ_CYC - 1);

    ld_state_e        r_state;
    ld_state_e        w_next_state;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_done;
    logic             w_start_ok;
    logic             w_start_bad;
    logic             w_accept;
    logic             w_wr_done;
    logic             w_rd_done;
    logic             w_last;
    logic             w_finish_ok;
    logic             w_finish_bad;
    logic [15:0]      w_count_inc;

    logic             r_s_ready;
    logic [14:0]      r_arda;
    logic [7:0]       r_ardd_o;
    logic             r_ardd_oe;
    logic             r_ardwe;
    logic             r_ardoe;
    logic [2:0]       r_pagemode;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [15:0]      r_checksum;
    logic [15:0]      r_rsum;
    logic [15:0]      r_count;
    logic [15:0]      r_len;
    logic             r_verify;
    logic [2:0]       r_mode;

    vp_cyc_timer u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    assign w_count_inc = r_count + 16'd1;

    // Loader state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, phase timer loads and datapath update strobes.
    always_comb begin
        w_next_state = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_val    = {TMR_W{1'b0}};
        w_start_ok   = 1'b0;
        w_start_bad  = 1'b0;
        w_accept     = 1'b0;
        w_wr_done    = 1'b0;
        w_rd_done    = 1'b0;
        w_last       = (w_count_inc == r_len);
        w_finish_ok  = 1'b0;
        w_finish_bad = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_game_len > MAX_GAME_LEN) begin
                        w_start_bad = 1'b1;
                    end else if (i_game_len == 16'd0) begin
                        w_start_ok   = 1'b1;
                        w_next_state = ST_FINISH;
                    end else begin
                        w_start_ok   = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (i_s_valid && r_s_ready) begin
                    w_accept     = 1'b1;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = SETUP_LD;
                    w_next_state = ST_W_SETUP;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_W_SETUP: begin
                if (w_tmr_done) begin
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = PULSE_LD;
                    w_next_state = ST_W_PULSE;
                end else begin
                    w_next_state = ST_W_SETUP;
                end
            end
            ST_W_PULSE: begin
                if (w_tmr_done) begin
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = HOLD_LD;
                    w_next_state = ST_W_HOLD;
                end else begin
                    w_next_state = ST_W_PULSE;
                end
            end
            ST_W_HOLD: begin
                if (w_tmr_done) begin
                    w_wr_done = 1'b1;
                    if (!w_last) begin
                        w_next_state = ST_FETCH;
                    end else if (r_verify) begin
                        w_next_state = ST_R_SETUP;
                    end else begin
                        w_next_state = ST_FINISH;
                    end
                end else begin
                    w_next_state = ST_W_HOLD;
                end
            end
            ST_R_SETUP: begin
                w_tmr_load   = 1'b1;
                w_tmr_val    = READ_LD;
                w_next_state = ST_R_WAIT;
            end
            ST_R_WAIT: begin
                if (w_tmr_done) begin
                    w_rd_done    = 1'b1;
                    w_next_state = w_last ? ST_FINISH : ST_R_SETUP;
                end else begin
                    w_next_state = ST_R_WAIT;
                end
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
                if (r_verify && (r_rsum != r_checksum)) begin
                    w_finish_bad = 1'b1;
                end else begin
                    w_finish_ok = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Registered bus strobes and datapath; strobes follow the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s_ready  <= 1'b0;
            r_arda     <= 15'd0;
            r_ardd_o   <= 8'h00;
            r_ardd_oe  <= 1'b0;
            r_ardwe    <= 1'b1;
            r_ardoe    <= 1'b1;
            r_pagemode <= PM_SEND;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_checksum <= 16'd0;
            r_rsum     <= 16'd0;
            r_count    <= 16'd0;
            r_len      <= 16'd0;
            r_verify   <= 1'b0;
            r_mode     <= PM_SEND;
        end else begin
            r_s_ready <= (w_next_state == ST_FETCH);
            r_ardwe   <= (w_next_state != ST_W_PULSE);
            // Data drive starts one cycle into the strobe so the cart has released ARDD.
            r_ardd_oe <= (w_next_state == ST_W_PULSE) && (r_state == ST_W_PULSE);
            r_ardoe   <= (w_next_state != ST_R_WAIT);
            r_busy    <= (w_next_state != ST_IDLE);
            r_done    <= w_finish_ok;
            r_err     <= w_finish_bad | w_start_bad;
            if (w_start_ok) begin
                r_arda     <= 15'd0;
                r_count    <= 16'd0;
                r_checksum <= 16'd0;
                r_rsum     <= 16'd0;
                r_len      <= i_game_len;
                r_verify   <= i_verify;
                r_mode     <= i_mode_in;
                if (i_game_len != 16'd0) begin
                    r_pagemode <= PM_SEND;
                end
            end else if (w_accept) begin
                r_ardd_o   <= i_s_data;
                r_checksum <= csum_add(r_checksum, i_s_data);
            end else if (w_wr_done) begin
                r_count <= w_last ? 16'd0 : w_count_inc;
                r_arda  <= (w_last && r_verify) ? 15'd0 : (r_arda + 15'd1);
            end else if (w_rd_done) begin
                r_rsum  <= csum_add(r_rsum, i_ardd_i);
                r_count <= w_count_inc;
                r_arda  <= r_arda + 15'd1;
            end else if (w_finish_ok) begin
                r_pagemode <= r_mode;
            end
        end
    end

    assign o_s_ready  = r_s_ready;
    assign o_arda     = r_arda;
    assign o_ardd_o   = r_ardd_o;
    assign o_ardd_oe  = r_ardd_oe;
    assign o_ardwe    = r_ardwe;
    assign o_ardoe    = r_ardoe;
    assign o_pagemode = r_pagemode;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_checksum = r_checksum;

endmodule

// File: tb/tb_vp_cart_loader.sv
// Randomized bench for vp_cart_loader: a byte-level SRAM model on the ARD port
// and an image-level reference (expected RAM contents, sums, outcome, timing).
module tb_vp_cart_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] game_len = 16'd0;
    logic        verify_in = 1'b0;
    logic [2:0]  mode_in = 3'b000;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [14:0] arda;
    logic [7:0]  ardd_o;
    logic        ardd_oe;
    logic [7:0]  ardd_i;
    logic        ardwe;
    logic        ardoe;
    logic [2:0]  pagemode;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] checksum;

    vp_cart_loader dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_game_len (game_len),
        .i_verify   (verify_in),
        .i_mode_in  (mode_in),
        .i_s_data   (s_data),
        .i_s_valid  (s_valid),
        .o_s_ready  (s_ready),
        .o_arda     (arda),
        .o_ardd_o   (ardd_o),
        .o_ardd_oe  (ardd_oe),
        .i_ardd_i   (ardd_i),
        .o_ardwe    (ardwe),
        .o_ardoe    (ardoe),
        .o_pagemode (pagemode),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err),
        .o_checksum (checksum)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SRAM model; one address can be made to read back inverted.
    logic [7:0]  mem [0:32767];
    logic        corrupt_en = 1'b0;
    logic [14:0] corrupt_a = 15'd0;
    assign ardd_i = mem[arda] ^ ((corrupt_en && (arda == corrupt_a)) ? 8'hFF : 8'h00);

    int          cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          oe_viol = 0;
    int          fall_q[$];
    int          pulse_q[$];
    int          oeh_q[$];
    int          rd_q[$];
    logic [14:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [7:0]  stim_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus monitor: records each write strobe, each read window and the pulses.
    initial begin : monitor
        logic        prev_we;
        logic        prev_oe;
        int          lowlen;
        int          oelen;
        int          rdlen;
        logic [14:0] wa;
        logic [7:0]  wd;
        prev_we = 1'b1; prev_oe = 1'b1;
        lowlen = 0; oelen = 0; rdlen = 0; wa = 15'd0; wd = 8'h00;
        forever begin
            @(negedge clk);
            if (ardd_oe && ardwe) oe_viol++;
            if (!ardwe) begin
                if (prev_we) begin
                    fall_q.push_back(cyc);
                    lowlen = 0;
                    oelen = 0;
                end
                lowlen++;
                if (ardd_oe) begin
                    oelen++;
                    wa = arda;
                    wd = ardd_o;
                end
            end else if (!prev_we) begin
                wa_q.push_back(wa);
                wd_q.push_back(wd);
                pulse_q.push_back(lowlen);
                oeh_q.push_back(oelen);
                mem[wa] = wd;
            end
            if (!ardoe) begin
                if (prev_oe) rdlen = 0;
                rdlen++;
            end else if (!prev_oe) begin
                rd_q.push_back(rdlen);
            end
            prev_we = ardwe;
            prev_oe = ardoe;
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    end

    task automatic clear_obs();
        fall_q.delete(); pulse_q.delete(); oeh_q.delete(); rd_q.delete();
        wa_q.delete(); wd_q.delete();
        done_cnt = 0; err_cnt = 0; oe_viol = 0;
    endtask

    // One complete load of stim_q; held=1 keeps S_VALID high, held=0 stalls 10 cycles between bytes.
    task automatic do_load(input int len, input bit vfy, input logic [2:0] mode, input bit held, input int corrupt);
        logic [15:0] exp_sum;
        logic [15:0] exp_rsum;
        bit          exp_pass;
        int          n;
        int          bad;
        int          stall_bad;
        int          stall_seen;
        corrupt_en = (corrupt >= 0);
        corrupt_a  = (corrupt >= 0) ? 15'(corrupt) : 15'd0;
        clear_obs();
        exp_sum = 16'd0;
        exp_rsum = 16'd0;
        for (int i = 0; i < len; i++) begin
            exp_sum  = exp_sum + {8'h00, stim_q[i]};
            exp_rsum = exp_rsum + {8'h00, stim_q[i] ^ ((i == corrupt) ? 8'hFF : 8'h00)};
        end
        exp_pass = !vfy || (exp_rsum == exp_sum);
        stall_bad = 0;
        stall_seen = 0;

        @(negedge clk);
        game_len = 16'(len); verify_in = vfy; mode_in = mode; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_rise", {31'd0, busy}, 32'd1);
        check_eq("pm_send_on_start", {29'd0, pagemode}, 32'd4);

        for (int i = 0; i < len; i++) begin
            s_data = stim_q[i];
            s_valid = 1'b1;
            n = 0;
            while (!s_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) begin
                check_eq("s_ready_timeout", 32'(n), 32'd0);
                break;
            end
            @(posedge clk);
            @(negedge clk);
            if (!held && i < len - 1) begin
                s_valid = 1'b0;
                repeat (10) begin
                    if (s_ready) begin
                        stall_seen++;
                        if (!ardwe || ardd_oe || arda != 15'(i + 1)) stall_bad++;
                    end
                    @(negedge clk);
                end
            end
        end
        s_valid = 1'b0;

        n = 0;
        while (done_cnt + err_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("finish_timeout", {31'd0, n >= 3000}, 32'd0);
        repeat (3) @(negedge clk);

        check_eq("done_cnt", 32'(done_cnt), {31'd0, exp_pass});
        check_eq("err_cnt", 32'(err_cnt), {31'd0, !exp_pass});
        check_eq("pagemode_end", {29'd0, pagemode}, {29'd0, exp_pass ? mode : 3'b100});
        check_eq("busy_end", {31'd0, busy}, 32'd0);
        check_eq("checksum", {16'd0, checksum}, {16'd0, exp_sum});
        check_eq("write_count", 32'(wa_q.size()), 32'(len));
        bad = 0;
        for (int i = 0; i < wa_q.size() && i < len; i++)
            if (wa_q[i] != 15'(i) || wd_q[i] != stim_q[i]) bad++;
        check_eq("write_addr_data", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < pulse_q.size(); i++)
            if (pulse_q[i] != 4 || oeh_q[i] != 3) bad++;
        check_eq("we_pulse_shape", 32'(bad), 32'd0);
        check_eq("oe_while_we_high", 32'(oe_viol), 32'd0);
        if (held) begin
            bad = 0;
            for (int i = 1; i < fall_q.size(); i++)
                if (fall_q[i] - fall_q[i-1] != 8) bad++;
            check_eq("byte_spacing", 32'(bad), 32'd0);
        end else begin
            check_eq("stall_bus_idle", 32'(stall_bad), 32'd0);
            check_eq("stall_seen", {31'd0, stall_seen > 0 || len < 2}, 32'd1);
        end
        check_eq("read_count", 32'(rd_q.size()), vfy ? 32'(len) : 32'd0);
        bad = 0;
        for (int i = 0; i < rd_q.size(); i++)
            if (rd_q[i] != 3) bad++;
        check_eq("read_oe_len", 32'(bad), 32'd0);
        corrupt_en = 1'b0;
    endtask

    task automatic do_bad_len(input logic [15:0] len);
        logic [2:0] pm_before;
        pm_before = pagemode;
        @(negedge clk);
        game_len = len; mode_in = 3'b010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("badlen_err", {31'd0, err}, 32'd1);
        check_eq("badlen_busy", {31'd0, busy}, 32'd0);
        check_eq("badlen_pm", {29'd0, pagemode}, {29'd0, pm_before});
        @(negedge clk);
        check_eq("badlen_err_pulse", {31'd0, err}, 32'd0);
    endtask

    task automatic fill_random(input int len);
        stim_q.delete();
        for (int i = 0; i < len; i++) stim_q.push_back(8'($urandom));
    endtask

    initial begin : main
        int n;
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_arda", {17'd0, arda}, 32'd0);
        check_eq("rst_ardd_o", {24'd0, ardd_o}, 32'd0);
        check_eq("rst_ardd_oe", {31'd0, ardd_oe}, 32'd0);
        check_eq("rst_ardwe", {31'd0, ardwe}, 32'd1);
        check_eq("rst_ardoe", {31'd0, ardoe}, 32'd1);
        check_eq("rst_pagemode", {29'd0, pagemode}, 32'd4);
        check_eq("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_checksum", {16'd0, checksum}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(4, 1'b0, 3'b001, 1'b1, -1);
        check_eq("checksum_00AA", {16'd0, checksum}, 32'h0000_00AA);
        do_load(4, 1'b1, 3'b001, 1'b1, -1);
        do_load(4, 1'b1, 3'b001, 1'b1, 2);

        fill_random(4);
        do_load(4, 1'b1, 3'b101, 1'b0, -1);

        // Zero-length image completes without touching the bus.
        clear_obs();
        @(negedge clk);
        game_len = 16'd0; mode_in = 3'b011; verify_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("len0_busy", {31'd0, busy}, 32'd1);
        check_eq("len0_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        check_eq("len0_done", {31'd0, done}, 32'd1);
        check_eq("len0_busy_fall", {31'd0, busy}, 32'd0);
        check_eq("len0_pm", {29'd0, pagemode}, 32'd3);
        check_eq("len0_no_write", 32'(fall_q.size()), 32'd0);

        do_bad_len(16'd40000);
        do_bad_len(16'd32769);

        // Reset while the write strobe is low.
        fill_random(3);
        clear_obs();
        @(negedge clk);
        game_len = 16'd3; verify_in = 1'b0; mode_in = 3'b001; start = 1'b1;
        @(negedge clk);
        start = 1'b0; s_data = 8'h5A; s_valid = 1'b1;
        n = 0;
        while (!(ardwe == 1'b0 && ardd_oe == 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_w_pulse", {31'd0, n >= 100}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_ardwe", {31'd0, ardwe}, 32'd1);
        check_eq("rst_mid_ardd_oe", {31'd0, ardd_oe}, 32'd0);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        s_valid = 1'b0;
        done_cnt = 0; err_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_mid_no_done_err", 32'(done_cnt + err_cnt), 32'd0);
        do_load(3, 1'b1, 3'b110, 1'b1, -1);

        for (int k = 0; k < 8; k++) begin
            int  len;
            bit  vfy;
            int  cor;
            len = int'($urandom_range(1, 24));
            vfy = 1'($urandom_range(0, 1));
            cor = (vfy && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1;
            fill_random(len);
            do_load(len, vfy, 3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), cor);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
